saturn_pc_stack: RTL and testbench

Parametrised program-counter and hardware return-stack unit for the Saturn core. It replaces the increment-only PC register with a block that also executes decoder-issued jumps, relative branches, calls, returns and explicit stack transfers (RSTK=C / C=RSTK). It sits beside the register file, driven by the phase sequencer and the decoder, and gated by bus-busy like the rest of the register blocks.

---
 rtl/saturn_pkg.sv | 20 ++
 rtl/saturn_rstk_lifo.sv | 46 ++++
 rtl/saturn_pc_stack.sv | 104 ++++++++++
 tb/tb_saturn_pc_stack.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_pkg.sv
// Shared encodings for the Saturn PC / return-stack unit: command codes and
// phase-strobe bit positions.
package saturn_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_JUMP = 3'd1,
        CMD_REL  = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RTN  = 3'd4,
        CMD_PUSH = 3'd5,
        CMD_POP  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_e;

    // Bit positions inside the one-hot phase strobe vector
    localparam int PH_INC = 1;   // PC auto-increment phase
    localparam int PH_CMD = 3;   // command acceptance phase

endpackage

// File: rtl/saturn_rstk_lifo.sv
// Hardware return stack as a shift array: entry 0 is the top. Pushing onto a
// full stack drops the oldest entry; popping an empty stack yields zero. Both
// overflow and underflow raise a one-cycle error pulse.
module saturn_rstk_lifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [LVL_W-1:0] o_level,
    output logic             o_err
);

    logic [WIDTH-1:0] stack [DEPTH];

    // Entries beyond the level are always zero, so the top reads 0 when empty
    assign o_top = stack[0];

    // Shift the array on push/pop and track occupancy; push and pop never coincide
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            o_level <= '0;
            o_err   <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (i_push) begin
                stack[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) stack[i] <= stack[i-1];
                if (o_level == LVL_W'(DEPTH)) o_err <= 1'b1;
                else                          o_level <= o_level + LVL_W'(1);
            end else if (i_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) stack[i] <= stack[i+1];
                stack[DEPTH-1] <= '0;
                if (o_level == '0) o_err <= 1'b1;
                else               o_level <= o_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/saturn_pc_stack.sv
// Saturn program counter with jump / relative branch / call / return and
// explicit return-stack transfers. Commands retire only in an active phase-3
// cycle; the PC auto-increments in active phase-1 cycles once the first
// phase 3 after reset has been seen.
module saturn_pc_stack
    import saturn_pkg::*;
#(
    parameter int PC_WIDTH   = 20,
    parameter int RSTK_DEPTH = 8,
    parameter int OFFSET_W   = 16,
    parameter int LVL_W      = $clog2(RSTK_DEPTH + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clk_en,
    input  logic [3:0]                 i_phases,
    input  logic                       i_bus_busy,
    input  logic                       i_cmd_valid,
    input  logic [2:0]                 i_cmd,
    input  logic [PC_WIDTH-1:0]        i_target,
    input  logic signed [OFFSET_W-1:0] i_offset,
    output logic [PC_WIDTH-1:0]        o_current_pc,
    output logic [PC_WIDTH-1:0]        o_rstk_top,
    output logic [PC_WIDTH-1:0]        o_pop_data,
    output logic [LVL_W-1:0]           o_rstk_level,
    output logic                       o_rstk_empty,
    output logic                       o_rstk_full,
    output logic                       o_cmd_ack,
    output logic                       o_rstk_err
);

    // Relative branch target: sign-extend the offset, wrap modulo 2^PC_WIDTH
    function automatic logic [PC_WIDTH-1:0] rel_target(
        input logic [PC_WIDTH-1:0]        pc,
        input logic signed [OFFSET_W-1:0] off
    );
        logic signed [PC_WIDTH-1:0] off_ext;
        off_ext = PC_WIDTH'(off);
        return pc + off_ext;
    endfunction

    logic                active;
    logic                accept;
    logic                just_reset;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] push_data;
    cmd_e                cmd;
    logic                unused_phases;

    assign unused_phases = ^{i_phases[0], i_phases[2]};

    assign active    = i_clk_en && !i_bus_busy;
    assign accept    = active && i_phases[PH_CMD] && i_cmd_valid;
    assign cmd       = cmd_e'(i_cmd);
    assign push      = accept && (cmd == CMD_CALL || cmd == CMD_PUSH);
    assign pop       = accept && (cmd == CMD_RTN  || cmd == CMD_POP);
    // CALL saves the PC of the calling instruction, PUSH stores the operand
    assign push_data = (cmd == CMD_CALL) ? o_current_pc : i_target;

    assign o_rstk_empty = (o_rstk_level == '0);
    assign o_rstk_full  = (o_rstk_level == LVL_W'(RSTK_DEPTH));

    saturn_rstk_lifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RSTK_DEPTH),
        .LVL_W (LVL_W)
    ) u_rstk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (push_data),
        .o_top   (o_rstk_top),
        .o_level (o_rstk_level),
        .o_err   (o_rstk_err)
    );

    // PC update, command retirement and the post-reset increment inhibit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_current_pc <= '0;
            o_pop_data   <= '0;
            o_cmd_ack    <= 1'b0;
            just_reset   <= 1'b1;
        end else begin
            o_cmd_ack <= accept;
            if (active && i_phases[PH_CMD]) just_reset <= 1'b0;
            if (accept) begin
                case (cmd)
                    CMD_JUMP: o_current_pc <= i_target;
                    CMD_REL:  o_current_pc <= rel_target(o_current_pc, i_offset);
                    CMD_CALL: o_current_pc <= i_target;
                    CMD_RTN:  o_current_pc <= o_rstk_top;
                    CMD_POP:  o_pop_data   <= o_rstk_top;
                    default:  ;
                endcase
            end else if (active && i_phases[PH_INC] && !just_reset) begin
                o_current_pc <= o_current_pc + PC_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_saturn_pc_stack.sv
// Bench for saturn_pc_stack: directed scenarios followed by randomized
// traffic, all compared each cycle against a queue-based reference model.
module tb_saturn_pc_stack;

    localparam int PCW   = 20;
    localparam int DEPTH = 8;
    localparam int OW    = 16;
    localparam int LW    = 4;
    localparam int MASK  = 32'h000F_FFFF;

    localparam logic [3:0] PH0 = 4'b0001;
    localparam logic [3:0] PH1 = 4'b0010;
    localparam logic [3:0] PH2 = 4'b0100;
    localparam logic [3:0] PH3 = 4'b1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           clk_en;
    logic [3:0]     phases;
    logic           bus_busy;
    logic           cmd_valid;
    logic [2:0]     cmd;
    logic [PCW-1:0] target;
    logic [OW-1:0]  offset;
    logic [PCW-1:0] current_pc;
    logic [PCW-1:0] rstk_top;
    logic [PCW-1:0] pop_data;
    logic [LW-1:0]  rstk_level;
    logic           rstk_empty;
    logic           rstk_full;
    logic           cmd_ack;
    logic           rstk_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int              m_pc;
    bit              m_jr;
    logic [PCW-1:0]  m_q[$];
    int              m_pop;
    bit              m_ack;
    bit              m_err;

    always #5 clk = ~clk;

    saturn_pc_stack #(
        .PC_WIDTH   (PCW),
        .RSTK_DEPTH (DEPTH),
        .OFFSET_W   (OW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clk_en     (clk_en),
        .i_phases     (phases),
        .i_bus_busy   (bus_busy),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .i_target     (target),
        .i_offset     (offset),
        .o_current_pc (current_pc),
        .o_rstk_top   (rstk_top),
        .o_pop_data   (pop_data),
        .o_rstk_level (rstk_level),
        .o_rstk_empty (rstk_empty),
        .o_rstk_full  (rstk_full),
        .o_cmd_ack    (cmd_ack),
        .o_rstk_err   (rstk_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PCW-1:0] m_pop_val();
        if (m_q.size() == 0) begin
            m_err = 1'b1;
            return '0;
        end
        return m_q.pop_front();
    endfunction

    task automatic m_push(input logic [PCW-1:0] v);
        m_q.push_front(v);
        if (m_q.size() > DEPTH) begin
            void'(m_q.pop_back());
            m_err = 1'b1;
        end
    endtask

    // Model of one clock edge using the inputs currently applied
    task automatic model_edge();
        int so;
        if (rst) begin
            m_pc = 0; m_q.delete(); m_pop = 0; m_ack = 0; m_err = 0; m_jr = 1;
            return;
        end
        m_ack = 0;
        m_err = 0;
        if (!clk_en || bus_busy) return;
        if (phases[1] && !m_jr) m_pc = (m_pc + 1) & MASK;
        if (phases[3]) begin
            m_jr = 0;
            if (cmd_valid) begin
                m_ack = 1;
                case (cmd)
                    3'd1: m_pc = int'(target);
                    3'd2: begin so = $signed(offset); m_pc = (m_pc + so) & MASK; end
                    3'd3: begin m_push(PCW'(m_pc)); m_pc = int'(target); end
                    3'd4: m_pc = int'(m_pop_val());
                    3'd5: m_push(target);
                    3'd6: m_pop = int'(m_pop_val());
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        chk("pc",    current_pc, m_pc);
        chk("top",   rstk_top,   (m_q.size() != 0) ? m_q[0] : '0);
        chk("popd",  pop_data,   m_pop);
        chk("level", rstk_level, m_q.size());
        chk("empty", rstk_empty, m_q.size() == 0);
        chk("full",  rstk_full,  m_q.size() == DEPTH);
        chk("ack",   cmd_ack,    m_ack);
        chk("err",   rstk_err,   m_err);
    endtask

    task automatic cyc(input logic [3:0] ph, input logic v, input logic [2:0] c,
                       input logic [PCW-1:0] t, input logic [OW-1:0] o, input logic b);
        phases = ph; cmd_valid = v; cmd = c; target = t; offset = o; bus_busy = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int acks;

    initial begin
        rst = 1'b1; clk_en = 1'b1; phases = PH0; bus_busy = 1'b0;
        cmd_valid = 1'b0; cmd = 3'd0; target = '0; offset = '0;
        m_pc = 0; m_jr = 1; m_pop = 0; m_ack = 0; m_err = 0;

        // Reset state
        cyc(PH1, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH3, 1'b1, 3'd3, 20'h11111, '0, 1'b0);
        chk("rst_pc", current_pc, 0);
        chk("rst_level", rstk_level, 0);
        chk("rst_ack", cmd_ack, 0);
        rst = 1'b0;

        // No increment before the first phase 3, then one per phase 1
        cyc(PH1, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH2, 1'b0, 3'd0, '0, '0, 1'b0);
        chk("noinc_pc", current_pc, 0);
        cyc(PH3, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH0, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH1, 1'b0, 3'd0, '0, '0, 1'b0);
        chk("inc1_pc", current_pc, 1);
        cyc(PH2, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH3, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH0, 1'b0, 3'd0, '0, '0, 1'b0);
        cyc(PH1, 1'b0, 3'd0, '0, '0, 1'b0);
        chk("inc2_pc", current_pc, 2);
        cyc(PH1, 1'b0, 3'd0, '0, '0, 1'b1);
        chk("busy_pc", current_pc, 2);

        // JUMP, negative REL, wrap on increment
        cyc(PH3, 1'b1, 3'd1, 20'h12345, '0, 1'b0);
        chk("jump_pc", current_pc, 32'h12345);
        chk("jump_ack", cmd_ack, 1);
        cyc(PH3, 1'b1, 3'd2, '0, 16'hFFFE, 1'b0);
        chk("rel_pc", current_pc, 32'h12343);
        cyc(PH3, 1'b1, 3'd1, 20'hFFFFF, '0, 1'b0);
        cyc(PH1, 1'b0, 3'd0, '0, '0, 1'b0);
        chk("wrap_pc", current_pc, 0);

        // CALL / RTN
        cyc(PH3, 1'b1, 3'd1, 20'h00105, '0, 1'b0);
        cyc(PH3, 1'b1, 3'd3, 20'h0A000, '0, 1'b0);
        chk("call_pc", current_pc, 32'h0A000);
        chk("call_top", rstk_top, 32'h00105);
        chk("call_level", rstk_level, 1);
        cyc(PH3, 1'b1, 3'd4, '0, '0, 1'b0);
        chk("rtn_pc", current_pc, 32'h00105);
        chk("rtn_level", rstk_level, 0);
        chk("rtn_top", rstk_top, 0);

        // Overflow and underflow
        for (int i = 1; i <= 9; i++) begin
            cyc(PH3, 1'b1, 3'd5, PCW'(i), '0, 1'b0);
            chk("push_err", rstk_err, (i == 9));
        end
        chk("push_level", rstk_level, 8);
        chk("push_top", rstk_top, 9);
        chk("push_full", rstk_full, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc(PH3, 1'b1, 3'd6, '0, '0, 1'b0);
            chk("pop_data", pop_data, (i == 9) ? 0 : 10 - i);
            chk("pop_err", rstk_err, (i == 9));
        end
        chk("pop_empty", rstk_empty, 1);

        // Request held across a busy phase 3
        acks = 0;
        cyc(PH1, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b0); acks += cmd_ack;
        cyc(PH2, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b0); acks += cmd_ack;
        cyc(PH3, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b1); acks += cmd_ack;
        chk("busy_noack", cmd_ack, 0);
        cyc(PH0, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b0); acks += cmd_ack;
        cyc(PH1, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b0); acks += cmd_ack;
        cyc(PH2, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b0); acks += cmd_ack;
        cyc(PH3, 1'b1, 3'd1, 20'h0BEEF, '0, 1'b0); acks += cmd_ack;
        chk("held_pc", current_pc, 32'h0BEEF);
        cyc(PH0, 1'b0, 3'd0, '0, '0, 1'b0); acks += cmd_ack;
        chk("one_ack", acks, 1);

        // Reset beats an accepted CALL
        cyc(PH3, 1'b1, 3'd5, 20'h00777, '0, 1'b0);
        rst = 1'b1;
        cyc(PH3, 1'b1, 3'd3, 20'h0A000, '0, 1'b0);
        rst = 1'b0;
        chk("rstcall_pc", current_pc, 0);
        chk("rstcall_level", rstk_level, 0);
        chk("rstcall_ack", cmd_ack, 0);

        // Randomized traffic following the request/ack handshake
        cmd_valid = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic          v;
            logic [2:0]    c;
            logic [PCW-1:0] t;
            logic [OW-1:0] o;
            v = cmd_valid; c = cmd; t = target; o = offset;
            if (m_ack || rst) v = 1'b0;
            if (!v && $urandom_range(0, 9) < 4) begin
                v = 1'b1;
                c = 3'($urandom_range(0, 7));
                t = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : PCW'($urandom);
                o = OW'($urandom);
            end
            rst    = ($urandom_range(0, 199) == 0);
            clk_en = ($urandom_range(0, 9) != 0);
            cyc(4'b0001 << $urandom_range(0, 3), v, c, t, o, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
